sprite_blit_ctrl: RTL and testbench

SPRITE_BLIT_CTRL -- requirements
Module: sprite_blit_ctrl

---
 rtl/sprite_blit_ctrl.sv | 131 +++++++++++++
 tb/tb_sprite_blit_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blit_ctrl.sv
// Sprite blitter: copies one 8x8 sprite from ROM to the framebuffer, one pixel per FETCH/WAIT/WRITE pass.
// Optional macro SPRITE_TRANSPARENCY_EN: zero-valued pixels are skipped instead of written.
module sprite_blit_ctrl #(
   parameter int PIXEL_W     = 8,
   parameter int SPRITE_ID_W = 4,
   parameter int FB_WIDTH    = 320
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [16:0]              coordinates,
   input  logic [SPRITE_ID_W-1:0]   sprite_id,
   output logic                     busy,
   output logic                     done,
   output logic                     rom_en,
   output logic [SPRITE_ID_W+5:0]   rom_addr,
   input  logic [PIXEL_W-1:0]       rom_data,
   output logic                     fb_we,
   output logic [16:0]              fb_addr,
   output logic [PIXEL_W-1:0]       fb_data,
   input  logic                     fb_ready
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_WRITE, S_DONE} state_t;

   localparam logic [16:0] FB_W17 = 17'(FB_WIDTH);

   state_t                  r_state;
   logic [5:0]              r_cnt;
   logic [16:0]             r_coords;
   logic [SPRITE_ID_W-1:0]  r_sid;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_rom_en;
   logic [SPRITE_ID_W+5:0]  r_rom_addr;
   logic                    r_fb_we;
   logic [16:0]             r_fb_addr;
   logic [PIXEL_W-1:0]      r_fb_data;

   logic [5:0]              w_cnt_nxt;
   logic [16:0]             w_row_off;
   logic [16:0]             w_fb_addr;

   // Row-major 8x8 footprint; the 17-bit sum wraps naturally at the top of the address space.
   assign w_cnt_nxt = r_cnt + 6'd1;
   assign w_row_off = FB_W17 * {14'd0, r_cnt[5:3]};
   assign w_fb_addr = r_coords + w_row_off + {14'd0, r_cnt[2:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_coords   <= '0;
         r_sid      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_rom_en   <= 1'b0;
         r_rom_addr <= '0;
         r_fb_we    <= 1'b0;
         r_fb_addr  <= '0;
         r_fb_data  <= '0;
      end else begin
         r_done   <= 1'b0;
         r_rom_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_coords   <= coordinates;
                  r_sid      <= sprite_id;
                  r_cnt      <= '0;
                  r_busy     <= 1'b1;
                  r_rom_en   <= 1'b1;
                  r_rom_addr <= {sprite_id, 6'd0};
                  r_state    <= S_FETCH;
               end
            end
            S_FETCH: r_state <= S_WAIT;
            S_WAIT: begin
`ifdef SPRITE_TRANSPARENCY_EN
               if (rom_data == '0) begin
                  if (r_cnt == 6'd63) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_cnt      <= w_cnt_nxt;
                     r_rom_en   <= 1'b1;
                     r_rom_addr <= {r_sid, w_cnt_nxt};
                     r_state    <= S_FETCH;
                  end
               end else
`endif
               begin
                  r_fb_data <= rom_data;
                  r_fb_addr <= w_fb_addr;
                  r_fb_we   <= 1'b1;
                  r_state   <= S_WRITE;
               end
            end
            S_WRITE: begin
               // Address and data are held untouched while the framebuffer stalls.
               if (fb_ready) begin
                  r_fb_we <= 1'b0;
                  if (r_cnt == 6'd63) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_cnt      <= w_cnt_nxt;
                     r_rom_en   <= 1'b1;
                     r_rom_addr <= {r_sid, w_cnt_nxt};
                     r_state    <= S_FETCH;
                  end
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign rom_en   = r_rom_en;
   assign rom_addr = r_rom_addr;
   assign fb_we    = r_fb_we;
   assign fb_addr  = r_fb_addr;
   assign fb_data  = r_fb_data;

endmodule

// File: tb/tb_sprite_blit_ctrl.sv
// Directed bench for sprite_blit_ctrl: table of blits plus stall, ignored-start and mid-blit reset sequences.
module tb_sprite_blit_ctrl;

   logic        clk, rst_n, start, busy, done, rom_en, fb_we, fb_ready;
   logic [16:0] coordinates, fb_addr;
   logic [3:0]  sprite_id;
   logic [9:0]  rom_addr;
   logic [7:0]  rom_data, fb_data;

   sprite_blit_ctrl #(.PIXEL_W(8), .SPRITE_ID_W(4), .FB_WIDTH(320)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .coordinates(coordinates),
      .sprite_id(sprite_id), .busy(busy), .done(done), .rom_en(rom_en),
      .rom_addr(rom_addr), .rom_data(rom_data), .fb_we(fb_we), .fb_addr(fb_addr),
      .fb_data(fb_data), .fb_ready(fb_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef SPRITE_TRANSPARENCY_EN
   localparam int NW      = 32;
   localparam int EXP_LAT = 162;
`else
   localparam int NW      = 64;
   localparam int EXP_LAT = 194;
`endif

   int n_chk = 0;
   int n_err = 0;
   int wr_tot = 0;
   int n_done = 0;
   int n_ovl = 0;
   logic [16:0] wa [1024];
   logic [7:0]  wd [1024];

   // Zero at even counters, a sprite/counter-dependent nonzero value at odd ones.
   function automatic logic [7:0] rom_val(input logic [9:0] a);
      return a[0] ? {a[9:6], a[3:1], 1'b1} : 8'h00;
   endfunction

   function automatic int cnt_of(input int k);
`ifdef SPRITE_TRANSPARENCY_EN
      return 2 * k + 1;
`else
      return k;
`endif
   endfunction

   function automatic logic [16:0] exp_addr(input logic [16:0] c, input int k);
      int a;
      a = int'(c) + 320 * (k / 8) + (k % 8);
      return a[16:0];
   endfunction

   // ROM model: data appears exactly one cycle after rom_en, garbage otherwise.
   always @(posedge clk) rom_data <= rom_en ? rom_val(rom_addr) : 8'hEE;

   always @(negedge clk) begin
      if (rst_n) begin
         if (fb_we && fb_ready && wr_tot < 1024) begin
            wa[wr_tot] = fb_addr;
            wd[wr_tot] = fb_data;
            wr_tot = wr_tot + 1;
         end
         if (done) n_done = n_done + 1;
         if (rom_en && fb_we) n_ovl = n_ovl + 1;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_blit(input logic [16:0] c, input logic [3:0] s, input int stall,
                          input bit pulse, output int cyc, output int base);
      int st, bdrop, nw;
      base = wr_tot; st = 0; bdrop = 0;
      coordinates = c; sprite_id = s; start = 1'b1; fb_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 2;
      while (!done && cyc < 3000) begin
         nw = wr_tot - base;
         start = pulse && (cyc == 5 || cyc == 50);
         if (start) coordinates = 17'h1F0F0;
         if (stall > 0 && fb_we && cnt_of(nw) == 9 && st < stall) begin
            fb_ready = 1'b0;
            chk("stall_addr", fb_addr, exp_addr(c, 9));
            chk("stall_data", fb_data, rom_val({s, 6'd9}));
            st++;
         end else fb_ready = 1'b1;
         if (!busy) bdrop++;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0; fb_ready = 1'b1;
      chk("timeout", cyc < 3000, 1);
      chk("busy_hold", bdrop, 0);
      chk("busy_in_done", busy, 1);
      if (pulse) begin start = 1'b1; coordinates = 17'h0ABCD; end
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_done", busy, 0);
      nw = wr_tot - base;
      chk("num_writes", nw, NW);
      for (int k = 0; k < nw && k < 64; k++) begin
         chk($sformatf("wr_addr[%0d]", k), wa[base+k], exp_addr(c, cnt_of(k)));
         chk($sformatf("wr_data[%0d]", k), wd[base+k], rom_val({s, 6'(cnt_of(k))}));
      end
   endtask

   task automatic spot(input int base, input int nw, input int pix, input logic [16:0] ea);
      bit found, expf;
      logic [16:0] got;
      found = 0; got = '0;
      for (int k = 0; k < nw && k < 64; k++)
         if (cnt_of(k) == pix) begin found = 1; got = wa[base+k]; end
`ifdef SPRITE_TRANSPARENCY_EN
      expf = (pix % 2) == 1;
`else
      expf = 1;
`endif
      chk($sformatf("pix%0d_written", pix), found, expf);
      if (found) chk($sformatf("pix%0d_addr", pix), got, ea);
   endtask

   typedef struct {
      logic [16:0] c;
      logic [3:0]  s;
      int          stall;
      bit          pulse;
      int          pa;
      logic [16:0] ea;
      int          pb;
      logic [16:0] eb;
   } vec_t;

   vec_t vt [5];

   initial begin
      int cyc, base, nd0, w0, ren;
      vt[0] = '{17'd0,      4'd0,  0,  1'b0, 7,  17'd7,    63, 17'd2247};
      vt[1] = '{17'd100,    4'd5,  10, 1'b0, 9,  17'd421,  0,  17'd100};
      vt[2] = '{17'd131070, 4'd3,  0,  1'b0, 2,  17'd0,    8,  17'd318};
      vt[3] = '{17'd131071, 4'd15, 0,  1'b1, 63, 17'd2246, 1,  17'd0};
      vt[4] = '{17'd5000,   4'd9,  0,  1'b0, 57, 17'd7241, 15, 17'd5327};

      rst_n = 1'b1; start = 1'b0; fb_ready = 1'b1; coordinates = '0; sprite_id = '0;
      #2 rst_n = 1'b0;
      #1 chk("reset_outs", {busy, done, rom_en, fb_we, fb_addr, fb_data, rom_addr}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         nd0 = n_done;
         do_blit(vt[i].c, vt[i].s, vt[i].stall, vt[i].pulse, cyc, base);
         chk($sformatf("latency[%0d]", i), cyc, EXP_LAT + vt[i].stall);
         chk($sformatf("done_count[%0d]", i), n_done - nd0, 1);
         spot(base, wr_tot - base, vt[i].pa, vt[i].ea);
         spot(base, wr_tot - base, vt[i].pb, vt[i].eb);
         if (vt[i].pulse) begin
            w0 = wr_tot; ren = 0;
            repeat (6) begin
               @(posedge clk); #1;
               if (rom_en || busy) ren++;
            end
            chk("no_queued_start", ren, 0);
            chk("no_extra_writes", wr_tot - w0, 0);
            chk("no_extra_done", n_done - nd0, 1);
         end
      end

      // Mid-blit reset: abandon around pixel 30, then restart on the first edge after release.
      nd0 = n_done; base = wr_tot; cyc = 0;
      coordinates = 17'd200; sprite_id = 4'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (cnt_of(wr_tot - base) < 30 && cyc < 1000) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("reset_wait_timeout", cyc < 1000, 1);
      rst_n = 1'b0;
      #1 chk("midreset_outs", {busy, done, rom_en, fb_we, fb_addr, fb_data, rom_addr}, 0);
      w0 = wr_tot;
      repeat (3) @(posedge clk);
      #1 chk("midreset_no_done", n_done - nd0, 0);
      chk("midreset_no_writes", wr_tot - w0, 0);
      @(negedge clk) rst_n = 1'b1;
      nd0 = n_done;
      do_blit(17'd300, 4'd7, 0, 1'b0, cyc, base);
      chk("post_reset_latency", cyc, EXP_LAT);
      chk("post_reset_done", n_done - nd0, 1);
      spot(base, wr_tot - base, 1, 17'd301);

      chk("rom_fb_overlap", n_ovl, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
